tile_background_renderer: RTL

Pipelined, scrollable tile-map background generator for the VGA path. It replaces fixed wall/floor region logic with an internal, CPU-writable tile map of `MAP_COLS` x `MAP_ROWS` entries and per-tile two-colour patterns. It also adds a status-bar blanking band and per-frame scroll. It sits between the VGA controller (`DrawX`/`DrawY`) and the sprite compositor, and produces registered RGB with fixed latency.

---
 rtl/tile_background_renderer_pkg.sv | 46 ++++
 rtl/tile_background_renderer_pattern_rom.sv | 27 ++
 rtl/tile_background_renderer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tile_background_renderer_pkg.sv
// Shared types, palette and tile-pattern contents for the tile-map background renderer.
package bg_pkg;

    localparam int TILE_W    = 32;
    localparam int NUM_TILES = 8;
    localparam int TID_W     = $clog2(NUM_TILES);

    typedef logic [TID_W-1:0] tile_id_t;

    localparam tile_id_t TILE_FLOOR = tile_id_t'(0);
    localparam tile_id_t TILE_WALL  = tile_id_t'(1);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [23:0] TILE_FG [NUM_TILES] = '{
        24'h6f399d, 24'h6f399d, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };
    localparam logic [23:0] TILE_BG [NUM_TILES] = '{
        24'h3f2f4d, 24'h3f2f4d, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

    function automatic logic [10:0] wrap_once(input logic [10:0] v, input logic [10:0] ext);
        return (v >= ext) ? v - ext : v;
    endfunction

    // Wall is a running-bond brick: mortar rows at fy = 0 and TILE_W/2, head joints
    // offset by a quarter tile between the two courses. Every other tile is plain (BG).
    function automatic logic [TILE_W-1:0] tile_pattern(input tile_id_t tid, input int unsigned fy);
        logic [TILE_W-1:0] row;
        row = '0;
        if (tid == TILE_WALL && (fy % (TILE_W / 2)) != 0) begin
            row = '1;
            if (fy < TILE_W / 2) begin
                row[0]          = 1'b0;
                row[TILE_W / 2] = 1'b0;
            end else begin
                row[TILE_W / 4]     = 1'b0;
                row[3 * TILE_W / 4] = 1'b0;
            end
        end
        return row;
    endfunction

endpackage

// File: rtl/tile_background_renderer_pattern_rom.sv
// Synchronous-read tile pattern ROM, addressed by {tid, fy}; one TILE_W-bit row per read.
module tile_pattern_rom
    import bg_pkg::*;
#(
    parameter int ROM_TILE_W = bg_pkg::TILE_W,
    parameter int ROM_TILES  = bg_pkg::NUM_TILES,
    parameter int ADDR_W     = $clog2(ROM_TILES * ROM_TILE_W)
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr,
    output logic [ROM_TILE_W-1:0] data
);
    localparam int FINE_W = $clog2(ROM_TILE_W);

    logic [ROM_TILE_W-1:0] data_d, data_q;

    always_comb begin
        data_d = ROM_TILE_W'(tile_pattern(tile_id_t'(addr[ADDR_W-1:FINE_W]), 32'(addr[FINE_W-1:0])));
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/tile_background_renderer.sv
// Four-stage scrollable tile-map background: coordinate/address, map RAM, pattern ROM, colour.
module tile_background_renderer
    import bg_pkg::*;
#(
    parameter int TILE_W    = 32,
    parameter int MAP_COLS  = 20,
    parameter int MAP_ROWS  = 14,
    parameter int NUM_TILES = bg_pkg::NUM_TILES,
    parameter int STATUS_H  = 32,
    parameter int TID_W     = $clog2(NUM_TILES),
    parameter int ADDR_W    = $clog2(MAP_COLS * MAP_ROWS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              pixel_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        scroll_x,
    input  logic [9:0]        scroll_y,
    input  logic              map_we,
    input  logic [ADDR_W-1:0] map_addr,
    input  logic [TID_W-1:0]  map_tile,
    output logic              map_ready,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              rgb_valid
);
    localparam int          MAP_N  = MAP_COLS * MAP_ROWS;
    localparam int          FINE_W = $clog2(TILE_W);
    localparam logic [10:0] EXT_X  = 11'(MAP_COLS * TILE_W);
    localparam logic [10:0] EXT_Y  = 11'(MAP_ROWS * TILE_W);

    state_t              state_d, state_q;
    logic [ADDR_W-1:0]   cnt_d, cnt_q;
    logic                wr_en_d, wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_d, wr_addr_q;
    logic [TID_W-1:0]    wr_tile_d, wr_tile_q;
    logic [9:0]          sx_d, sx_q, sy_d, sy_q;
    logic [10:0]         wx, wy;

    logic                v1_d, v1_q, v2_q, v3_q, v4_d, v4_q;
    logic                blk1_d, blk1_q, blk2_q, blk3_q;
    logic [ADDR_W-1:0]   addr1_d, addr1_q;
    logic [FINE_W-1:0]   fx1_d, fx1_q, fx2_q, fx3_q;
    logic [FINE_W-1:0]   fy1_d, fy1_q, fy2_q;
    logic [TID_W-1:0]    tid2_q, tid3_q;
    logic [TILE_W-1:0]   pat3;
    logic [23:0]         rgb_d, rgb_q;

    logic [TID_W-1:0]    map_mem [MAP_N];

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = cnt_q;
        wr_tile_d = TID_W'(TILE_FLOOR);
        case (state_q)
            CLEAR: begin
                wr_en_d = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(MAP_N - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (map_we && ({1'b0, map_addr} < (ADDR_W + 1)'(MAP_N))) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = map_addr;
                    wr_tile_d = map_tile;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // A frame_start pixel already sees the new scroll, so S1 uses the next-state latch value.
    always_comb begin
        sx_d    = frame_start ? 10'(wrap_once({1'b0, scroll_x}, EXT_X)) : sx_q;
        sy_d    = frame_start ? 10'(wrap_once({1'b0, scroll_y}, EXT_Y)) : sy_q;
        wx      = wrap_once(11'(DrawX) + 11'(sx_d), EXT_X);
        wy      = wrap_once(11'(DrawY) - 11'(STATUS_H) + 11'(sy_d), EXT_Y);
        v1_d    = pixel_valid;
        blk1_d  = (DrawY < 10'(STATUS_H)) || (state_q == CLEAR);
        addr1_d = ADDR_W'(wy[10:FINE_W] * 11'(MAP_COLS) + 11'(wx[10:FINE_W]));
        fx1_d   = wx[FINE_W-1:0];
        fy1_d   = wy[FINE_W-1:0];
    end

    always_comb begin
        rgb_d = rgb_q;
        v4_d  = v3_q;
        if (v3_q) begin
            if (blk3_q)            rgb_d = 24'h000000;
            else if (pat3[fx3_q])  rgb_d = TILE_FG[tid3_q];
            else                   rgb_d = TILE_BG[tid3_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_tile_q <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            v4_q      <= 1'b0;
            blk1_q    <= 1'b0;
            blk2_q    <= 1'b0;
            blk3_q    <= 1'b0;
            addr1_q   <= '0;
            fx1_q     <= '0;
            fx2_q     <= '0;
            fx3_q     <= '0;
            fy1_q     <= '0;
            fy2_q     <= '0;
            tid3_q    <= '0;
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_tile_q <= wr_tile_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            v1_q      <= v1_d;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            v4_q      <= v4_d;
            blk1_q    <= blk1_d;
            blk2_q    <= blk1_q;
            blk3_q    <= blk2_q;
            addr1_q   <= addr1_d;
            fx1_q     <= fx1_d;
            fx2_q     <= fx1_q;
            fx3_q     <= fx2_q;
            fy1_q     <= fy1_d;
            fy2_q     <= fy1_q;
            tid3_q    <= tid2_q;
            rgb_q     <= rgb_d;
        end
    end

    // NOTE: the map RAM has no reset; the CLEAR sweep initialises it.
    // Writes are registered one stage so a write presented alongside a pixel lands on the
    // same edge as that pixel's read, which therefore returns the old tile.
    always_ff @(posedge Clk) begin
        if (wr_en_q) map_mem[wr_addr_q] <= wr_tile_q;
        tid2_q <= map_mem[addr1_q];
    end

    tile_pattern_rom #(
        .ROM_TILE_W (TILE_W),
        .ROM_TILES  (NUM_TILES)
    ) u_rom (
        .clk  (Clk),
        .addr ({tid2_q, fy2_q}),
        .data (pat3)
    );

    assign map_ready = (state_q == RUN);
    assign Red       = rgb_q[23:16];
    assign Green     = rgb_q[15:8];
    assign Blue      = rgb_q[7:0];
    assign rgb_valid = v4_q;

endmodule
